// File: rtl/crc_frame_stream.sv
// Streaming CRC framer: passes FRAME_LEN payload bytes, then appends the CRC MSB byte first.
// Define CRC_FRAME_STATS_EN to add the 16-bit frame_count output.
module crc_frame_stream #(
  parameter int              CRC_W      = 8,
  parameter logic [CRC_W-1:0] POLYNOMIAL = 8'h07,
  parameter logic [CRC_W-1:0] INITIAL    = 8'hFF,
  parameter int              FRAME_LEN  = 8,
  parameter int              CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic [CNT_W-1:0] byte_counter,
`ifdef CRC_FRAME_STATS_EN
  output logic [15:0]      frame_count,
`endif
  output logic [CRC_W-1:0] crc_o
);

  localparam int NB = CRC_W / 8;
  localparam logic [CNT_W-1:0] LAST_PL = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] FLEN    = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_K  = CNT_W'(NB - 1);

  typedef enum logic {ST_PAYLOAD, ST_CRC} state_t;

  state_t           state_q, state_d;
  logic [CRC_W-1:0] crc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] k;
  logic [7:0]       crc_byte;
  logic             fire;

  function automatic logic [CRC_W-1:0] next_crc(
    input logic [CRC_W-1:0] c,
    input logic [7:0]       d
  );
    logic [CRC_W-1:0] r;
    logic             fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[CRC_W-1] ^ d[i];
      r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLYNOMIAL : '0);
    end
    return r;
  endfunction

  // Select the CRC byte for the current tail position, MSB byte first
  always_comb begin
    k        = cnt_q - FLEN;
    crc_byte = '0;
    for (int i = 0; i < NB; i++) begin
      if (k == CNT_W'(i)) crc_byte = crc_q[CRC_W-1-8*i -: 8];
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_PAYLOAD;
    else       state_q <= state_d;
  end

  // Next state and handshake outputs; both sides are held idle in reset
  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    m_valid = 1'b0;
    m_data  = s_data;
    m_last  = 1'b0;
    fire    = 1'b0;
    unique case (state_q)
      ST_PAYLOAD: begin
        m_valid = s_valid & ~reset;
        s_ready = m_ready & ~reset;
        fire    = m_valid & m_ready;
        if (fire && cnt_q == LAST_PL) state_d = ST_CRC;
      end
      ST_CRC: begin
        m_valid = ~reset;
        m_data  = crc_byte;
        m_last  = (k == LAST_K);
        fire    = m_valid & m_ready;
        if (fire && m_last) state_d = ST_PAYLOAD;
      end
      default: state_d = ST_PAYLOAD;
    endcase
  end

  // Position counter and CRC accumulator; CRC re-seeds after the last tail byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      crc_q <= INITIAL;
    end else if (fire) begin
      if (state_q == ST_PAYLOAD) begin
        crc_q <= next_crc(crc_q, s_data);
        cnt_q <= cnt_q + 1'b1;
      end else if (m_last) begin
        crc_q <= INITIAL;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

`ifdef CRC_FRAME_STATS_EN
  logic [15:0] frames_q;

  // Count completed frames, wrapping at 16 bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              frames_q <= '0;
    else if (fire && m_last) frames_q <= frames_q + 16'd1;
  end

  assign frame_count = frames_q;
`endif

  assign byte_counter = cnt_q;
  assign crc_o        = crc_q;

endmodule

// File: tb/tb_crc_frame_stream.sv
// Directed bench for crc_frame_stream: three parameter sets share one driver.
// Define CRC_FRAME_STATS_EN to also check frame_count.
module tb_crc_frame_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        m_ready;
  logic [1:0]  sel;

  always #5 clk = ~clk;

  logic        sv_a, sv_b, sv_c;
  logic        sr_a, sr_b, sr_c;
  logic [7:0]  md_a, md_b, md_c;
  logic        mv_a, mv_b, mv_c;
  logic        ml_a, ml_b, ml_c;
  logic [7:0]  bc_a, bc_b, bc_c;
  logic [7:0]  cr_a, cr_c;
  logic [15:0] cr_b;
`ifdef CRC_FRAME_STATS_EN
  logic [15:0] fc_a, fc_b, fc_c;
`endif

  assign sv_a = s_valid && sel == 2'd0;
  assign sv_b = s_valid && sel == 2'd1;
  assign sv_c = s_valid && sel == 2'd2;

  crc_frame_stream #(
    .CRC_W(8), .POLYNOMIAL(8'h07), .INITIAL(8'h00), .FRAME_LEN(9), .CNT_W(8)
  ) u_a (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(sv_a), .s_ready(sr_a),
    .m_data(md_a), .m_valid(mv_a), .m_ready(m_ready), .m_last(ml_a),
    .byte_counter(bc_a),
`ifdef CRC_FRAME_STATS_EN
    .frame_count(fc_a),
`endif
    .crc_o(cr_a)
  );

  crc_frame_stream #(
    .CRC_W(16), .POLYNOMIAL(16'h1021), .INITIAL(16'hFFFF), .FRAME_LEN(9), .CNT_W(8)
  ) u_b (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(sv_b), .s_ready(sr_b),
    .m_data(md_b), .m_valid(mv_b), .m_ready(m_ready), .m_last(ml_b),
    .byte_counter(bc_b),
`ifdef CRC_FRAME_STATS_EN
    .frame_count(fc_b),
`endif
    .crc_o(cr_b)
  );

  crc_frame_stream #(
    .CRC_W(8), .POLYNOMIAL(8'h07), .INITIAL(8'h00), .FRAME_LEN(1), .CNT_W(8)
  ) u_c (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(sv_c), .s_ready(sr_c),
    .m_data(md_c), .m_valid(mv_c), .m_ready(m_ready), .m_last(ml_c),
    .byte_counter(bc_c),
`ifdef CRC_FRAME_STATS_EN
    .frame_count(fc_c),
`endif
    .crc_o(cr_c)
  );

  logic        s_ready, m_valid, m_last;
  logic [7:0]  m_data, byte_counter;
  logic [15:0] crc_o;

  always_comb begin
    s_ready = sr_a; m_data = md_a; m_valid = mv_a;
    m_last = ml_a; byte_counter = bc_a; crc_o = {8'h00, cr_a};
    if (sel == 2'd1) begin
      s_ready = sr_b; m_data = md_b; m_valid = mv_b;
      m_last = ml_b; byte_counter = bc_b; crc_o = cr_b;
    end else if (sel == 2'd2) begin
      s_ready = sr_c; m_data = md_c; m_valid = mv_c;
      m_last = ml_c; byte_counter = bc_c; crc_o = {8'h00, cr_c};
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  string      msg = "123456789";
  logic [7:0] pl[$];
  logic [7:0] exq[$];
  bit         exl[$];
  logic [7:0] got[$];
  bit         lastq[$];
  logic [7:0] cntq[$];
  int         cur_flen;

  task automatic clear_q();
    pl.delete(); exq.delete(); exl.delete();
  endtask

  task automatic push_msg(input int nb, input logic [15:0] crc);
    for (int i = 0; i < 9; i++) begin
      pl.push_back(msg[i]);
      exq.push_back(msg[i]);
      exl.push_back(1'b0);
    end
    for (int j = 0; j < nb; j++) begin
      exq.push_back(8'(crc >> (8 * (nb - 1 - j))));
      exl.push_back(j == nb - 1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    s_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_stream(input int n_out, input bit stall, input int maxc);
    int idx = 0;
    int cyc = 0;
    bit xfer = 1'b0;
    bit forced = 1'b0;
    got.delete(); lastq.delete(); cntq.delete();
    s_valid = 1'b0;
    while (got.size() < n_out && cyc < maxc) begin
      @(negedge clk);
      if (xfer) begin
        idx++;
        s_valid = 1'b0;
      end
      if (!s_valid && idx < pl.size()) begin
        s_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        s_data  = pl[idx];
      end
      m_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (stall && !forced && int'(byte_counter) >= cur_flen) begin
        m_ready = 1'b0;
        forced  = 1'b1;
      end
      #1;
      xfer = s_valid && s_ready;
      if (m_valid && m_ready) begin
        got.push_back(m_data);
        lastq.push_back(m_last);
        cntq.push_back(byte_counter);
      end
      cyc++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    m_ready = 1'b1;
  endtask

  task automatic cmp_out(input string tag, input int period);
    chk({tag, "_count"}, got.size(), exq.size());
    for (int i = 0; i < got.size() && i < exq.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), got[i], exq[i]);
      chk($sformatf("%s_last%0d", tag, i), lastq[i], exl[i]);
      chk($sformatf("%s_cnt%0d", tag, i), cntq[i], i % period);
    end
  endtask

  initial begin
    sel = 2'd0; reset = 1'b1; s_valid = 1'b1; m_ready = 1'b1; s_data = 8'h31;
    cur_flen = 9;
    repeat (2) @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_cnt", byte_counter, 0);
    chk("rst_crc8", crc_o, 16'h0000);
    sel = 2'd1;
    #1;
    chk("rst_crc16", crc_o, 16'hFFFF);
    chk("rst_m_valid16", m_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    s_valid = 1'b0;

    sel = 2'd0; cur_flen = 9;
    clear_q(); push_msg(1, 16'h00F4);
    run_stream(exq.size(), 1'b0, 200);
    cmp_out("crc8", 10);
    chk("crc8_cnt_end", byte_counter, 0);
    chk("crc8_reinit", crc_o, 16'h0000);

    sel = 2'd1; cur_flen = 9;
    clear_q(); push_msg(2, 16'h29B1);
    run_stream(exq.size(), 1'b0, 200);
    cmp_out("crc16", 11);
    chk("crc16_reinit", crc_o, 16'hFFFF);

    sel = 2'd2; cur_flen = 1;
    clear_q();
    pl = '{8'h01, 8'h01};
    exq = '{8'h01, 8'h07, 8'h01, 8'h07};
    exl = '{1'b0, 1'b1, 1'b0, 1'b1};
    run_stream(exq.size(), 1'b0, 200);
    cmp_out("len1", 2);

    sel = 2'd1; cur_flen = 9;
    clear_q(); push_msg(2, 16'h29B1); push_msg(2, 16'h29B1);
    run_stream(exq.size(), 1'b1, 3000);
    cmp_out("stall", 11);

    sel = 2'd0; cur_flen = 9;
    clear_q(); push_msg(1, 16'h00F4);
    run_stream(5, 1'b0, 200);
    chk("abort_cnt_pre", byte_counter, 5);
    s_valid = 1'b1; s_data = pl[5]; m_ready = 1'b1;
    reset = 1'b1;
    #1;
    chk("abort_m_valid", m_valid, 0);
    chk("abort_s_ready", s_ready, 0);
    chk("abort_cnt", byte_counter, 0);
    chk("abort_crc", crc_o, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    s_valid = 1'b0;
    run_stream(exq.size(), 1'b0, 200);
    cmp_out("abort", 10);

`ifdef CRC_FRAME_STATS_EN
    do_reset();
    sel = 2'd2; cur_flen = 1;
    clear_q();
    pl = '{8'h01, 8'h02, 8'h03};
    exq = '{8'h01, 8'h07, 8'h02, 8'h0E, 8'h03, 8'h09};
    exl = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    run_stream(exq.size(), 1'b0, 200);
    cmp_out("stats", 2);
    chk("frame_count", fc_c, 16'd3);
    do_reset();
    chk("frame_count_rst", fc_c, 16'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
